// File: rtl/sdr_fifo_pkg.sv
// Shared defaults and types for the streaming sample buffer.
package sdr_fifo_pkg;

    localparam int DATA_W_DEF  = 12;
    localparam int ADDR_W_DEF  = 10;
    localparam int PREFILL_DEF = 4;

    typedef logic [DATA_W_DEF-1:0] sample_t;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/sdr_fifo_if.sv
// Write strobe/data in, registered sample stream and fill status out.
interface sdr_fifo_if
    import sdr_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              wr_en_i;
    logic [DATA_W-1:0] wr_data_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              full_o;
    logic              empty_o;
    logic [ADDR_W:0]   level_o;

    modport master (
        output wr_en_i, wr_data_i,
        input  rd_data_o, rd_valid_o, full_o, empty_o, level_o
    );

    modport slave (
        input  wr_en_i, wr_data_i,
        output rd_data_o, rd_valid_o, full_o, empty_o, level_o
    );

endinterface

// File: rtl/sdr_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module sdr_fifo_ram
    import sdr_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-first: a same-address write in this cycle is not visible until the next read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdr_fifo.sv
// Self-draining sample FIFO: starts emitting once PREFILL words are stored, re-arms when dry.
module sdr_fifo
    import sdr_fifo_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int PREFILL = PREFILL_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    sdr_fifo_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0] PREFILL_L = (ADDR_W+1)'(PREFILL);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, empty_q, rd_valid_q;
    drain_state_t      state_q, state_d;
    logic              rd_en, wr_ok;

    always_comb begin
        rd_en    = (state_q == ST_DRAIN) && !empty_q;
        wr_ok    = bus.wr_en_i && (!full_q || rd_en);
        level_d  = level_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_en);
        wr_ptr_d = wr_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        state_d  = state_q;
        if (level_d >= PREFILL_L) begin
            state_d = ST_DRAIN;
        end else if ((level_d == '0) && (state_q == ST_DRAIN)) begin
            state_d = ST_FILL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            state_q    <= ST_FILL;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= (level_d == DEPTH_L);
            empty_q    <= (level_d == '0);
            rd_valid_q <= rd_en;
            state_q    <= state_d;
        end
    end

    sdr_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_ok && !rst_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data_i),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q),
        .rdata_o (bus.rd_data_o)
    );

    assign bus.rd_valid_o = rd_valid_q;
    assign bus.full_o     = full_q;
    assign bus.empty_o    = empty_q;
    assign bus.level_o    = level_q;

endmodule

// File: tb/tb_sdr_fifo.sv
// Scoreboard bench for sdr_fifo: default instance plus a 4-deep instance for the full boundary.
module tb_sdr_fifo;
    import sdr_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdr_fifo_if #(.DATA_W(12), .ADDR_W(10)) m_bus ();
    sdr_fifo_if #(.DATA_W(12), .ADDR_W(2))  s_bus ();

    sdr_fifo #(.DATA_W(12), .ADDR_W(10), .PREFILL(4)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (m_bus)
    );

    sdr_fifo #(.DATA_W(12), .ADDR_W(2), .PREFILL(4)) u_small (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (s_bus)
    );

    int      n_tests = 0;
    int      n_fail  = 0;
    int      edge_cnt = 0;
    int      arm_edge = -1;
    sample_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) edge_cnt++;

    // Every emitted sample must match the oldest accepted write; the first after arming checks latency.
    always @(negedge clk) begin
        if (!rst && m_bus.rd_valid_o) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", exp_q.size(), 1);
            end else begin
                check("sb_data", m_bus.rd_data_o, exp_q.pop_front());
            end
            if (arm_edge >= 0) begin
                check("latency", edge_cnt - arm_edge, 5);
                arm_edge = -1;
            end
        end
    end

    task automatic write_word(input sample_t d);
        m_bus.wr_en_i   = 1'b1;
        m_bus.wr_data_i = d;
        exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        m_bus.wr_en_i = 1'b0;
        s_bus.wr_en_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        sample_t pat [8];
        pat = '{12'hACD, 12'hFFF, 12'hEBE, 12'hFDC, 12'hABC, 12'hFFF, 12'hDDD, 12'hCCC};
        m_bus.wr_en_i   = 1'b0;
        m_bus.wr_data_i = '0;
        s_bus.wr_en_i   = 1'b0;
        s_bus.wr_data_i = '0;

        // Reset
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rst_rd_data", m_bus.rd_data_o, 0);
        check("rst_rd_valid", m_bus.rd_valid_o, 0);
        check("rst_empty", m_bus.empty_o, 1);
        check("rst_full", m_bus.full_o, 0);
        check("rst_level", m_bus.level_o, 0);
        rst = 1'b0;

        // Prefill, order and steady level
        arm_edge = edge_cnt;
        for (int k = 0; k < 8; k++) begin
            write_word(pat[k]);
            check("prefill_level", m_bus.level_o, (k < 3) ? k + 1 : 4);
        end

        // Long stream across pointer wraps, ending on 0xCCC
        for (int i = 0; i < 4148; i++) begin
            write_word((i == 4147) ? 12'hCCC : sample_t'(i));
            if (i % 1000 == 0) check("stream_level", m_bus.level_o, 4);
        end

        // Underrun
        idle(10);
        check("under_valid", m_bus.rd_valid_o, 0);
        check("under_hold", m_bus.rd_data_o, 12'hCCC);
        check("under_empty", m_bus.empty_o, 1);
        check("under_level", m_bus.level_o, 0);
        check("under_sb", exp_q.size(), 0);
        arm_edge = edge_cnt;
        for (int k = 0; k < 6; k++) write_word(sample_t'(12'h100 + k));
        idle(12);
        check("resume_empty", m_bus.empty_o, 1);
        check("resume_sb", exp_q.size(), 0);

        // Full boundary on the 4-deep instance
        for (int k = 0; k < 4; k++) begin
            s_bus.wr_en_i   = 1'b1;
            s_bus.wr_data_i = sample_t'(k + 1);
            @(posedge clk);
            #1;
            check("small_level", s_bus.level_o, k + 1);
            check("small_full", s_bus.full_o, (k == 3) ? 1 : 0);
        end
        s_bus.wr_data_i = 12'd5;
        @(posedge clk);
        #1;
        check("full_wr_rd_full", s_bus.full_o, 1);
        check("full_wr_rd_level", s_bus.level_o, 4);
        check("full_wr_rd_valid", s_bus.rd_valid_o, 1);
        check("full_wr_rd_data", s_bus.rd_data_o, 1);
        s_bus.wr_en_i = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check("small_drain", s_bus.rd_data_o, k);
        end
        @(posedge clk);
        #1;
        check("small_dry_valid", s_bus.rd_valid_o, 0);
        check("small_dry_empty", s_bus.empty_o, 1);

        // Reset mid-stream
        arm_edge = edge_cnt;
        for (int k = 0; k < 10; k++) write_word(k[0] ? 12'hFFF : 12'hAAA);
        rst = 1'b1;
        m_bus.wr_en_i   = 1'b1;
        m_bus.wr_data_i = 12'hAAA;
        exp_q.delete();
        arm_edge = -1;
        @(posedge clk);
        #1;
        check("mrst_level", m_bus.level_o, 0);
        check("mrst_valid", m_bus.rd_valid_o, 0);
        check("mrst_data", m_bus.rd_data_o, 0);
        check("mrst_empty", m_bus.empty_o, 1);
        rst = 1'b0;
        m_bus.wr_en_i = 1'b0;
        arm_edge = edge_cnt;
        for (int k = 0; k < 5; k++) write_word(k[0] ? 12'hFFF : 12'hAAA);
        idle(12);
        check("final_sb", exp_q.size(), 0);
        check("final_empty", m_bus.empty_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
